// File: rtl/clk_period_meter.sv
// rtl/clk_period_meter.sv - rising-edge period / high-time meter with lock and loss detection
//
// Purpose: resynchronises an asynchronous, clock-like sig_in into clk_in and measures
//          its rising-to-rising period and high-phase length in clk_in cycles. It flags
//          frequency lock after consecutive in-tolerance periods and sets a sticky
//          timeout flag when no rising edge arrives for TIMEOUT cycles.
//
// Ports:
//   clk_in     in   1      system clock
//   reset      in   1      synchronous, active-low reset
//   sig_in     in   1      asynchronous measured signal
//   period     out  CNT_W  last rising-to-rising period, in clk_in cycles
//   high_time  out  CNT_W  last high-phase length (0 when that period had no falling edge)
//   valid      out  1      one-cycle pulse: period/high_time updated
//   locked     out  1      LOCK_CNT consecutive in-tolerance periods seen
//   timeout    out  1      sticky input-lost flag, cleared by the next rise or reset

module clk_period_meter #(
   parameter int CNT_W       = 32,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 10000000,
   parameter int TOL         = 2,
   parameter int LOCK_CNT    = 4
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             sig_in,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             valid,
   output logic             locked,
   output logic             timeout
);

   localparam int MC_W = $clog2(LOCK_CNT + 1);

   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] TOL_C     = CNT_W'(TOL);
   localparam logic [MC_W-1:0]  LOCK_C    = MC_W'(LOCK_CNT);
   localparam logic [MC_W-1:0]  MC_ONE    = MC_W'(1);

   typedef enum logic {
      IDLE = 1'b0,
      MEAS = 1'b1
   } state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sync;
   logic                   prev;
   logic [CNT_W-1:0]       cnt;
   logic [CNT_W-1:0]       hcnt;
   logic [CNT_W-1:0]       hlat;
   logic                   hseen;
   logic                   have_prev;
   logic [MC_W-1:0]        mcnt;

   logic                   s;
   logic                   rise;
   logic                   fall;
   logic [CNT_W-1:0]       diff;
   logic                   in_tol;

   assign s    = sync[SYNC_STAGES-1];
   assign rise = s & ~prev;
   assign fall = ~s & prev;

   // cnt still holds the period being closed when rise is seen; period holds the
   // previously published one, so their distance is the cycle-to-cycle jitter.
   assign diff   = (cnt >= period) ? (cnt - period) : (period - cnt);
   assign in_tol = (diff <= TOL_C);

   always_ff @(posedge clk_in) begin
      if (!reset) begin
         state     <= IDLE;
         sync      <= '0;
         prev      <= 1'b0;
         cnt       <= '0;
         hcnt      <= '0;
         hlat      <= '0;
         hseen     <= 1'b0;
         have_prev <= 1'b0;
         mcnt      <= '0;
         period    <= '0;
         high_time <= '0;
         valid     <= 1'b0;
         locked    <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         sync  <= {sync[SYNC_STAGES-2:0], sig_in};
         prev  <= s;
         valid <= 1'b0;

         if (rise) begin
            cnt <= CNT_ONE;
         end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_ONE;
         end

         if (rise) begin
            hcnt <= CNT_ONE;
         end else if (s && (hcnt != CNT_MAX)) begin
            hcnt <= hcnt + CNT_ONE;
         end

         // hseen records whether the current period has already had its falling edge
         if (fall) begin
            hlat  <= hcnt;
            hseen <= 1'b1;
         end else if (rise) begin
            hseen <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (rise) begin
                  state     <= MEAS;
                  timeout   <= 1'b0;
                  have_prev <= 1'b0;
               end
            end

            MEAS: begin
               if (rise) begin
                  period    <= cnt;
                  high_time <= hseen ? hlat : '0;
                  valid     <= 1'b1;
                  have_prev <= 1'b1;
                  // The first period after leaving IDLE has no valid predecessor.
                  if (have_prev) begin
                     if (in_tol) begin
                        if (mcnt < LOCK_C) begin
                           mcnt <= mcnt + MC_ONE;
                        end
                        if (mcnt >= (LOCK_C - MC_ONE)) begin
                           locked <= 1'b1;
                        end
                     end else begin
                        mcnt   <= '0;
                        locked <= 1'b0;
                     end
                  end
               end else if (cnt == TIMEOUT_C) begin
                  timeout <= 1'b1;
                  locked  <= 1'b0;
                  mcnt    <= '0;
                  state   <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_clk_period_meter.sv
// tb/tb_clk_period_meter.sv - self-checking bench for clk_period_meter

module tb_clk_period_meter;

   localparam int CNT_W    = 32;
   localparam int SYNC     = 2;
   localparam int TIMEOUT  = 3000;
   localparam int TOL      = 2;
   localparam int LOCK_CNT = 4;

   logic             clk_in;
   logic             reset;
   logic             sig_in;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] high_time;
   logic             valid;
   logic             locked;
   logic             timeout;

   clk_period_meter #(
      .CNT_W      (CNT_W),
      .SYNC_STAGES(SYNC),
      .TIMEOUT    (TIMEOUT),
      .TOL        (TOL),
      .LOCK_CNT   (LOCK_CNT)
   ) dut (
      .clk_in   (clk_in),
      .reset    (reset),
      .sig_in   (sig_in),
      .period   (period),
      .high_time(high_time),
      .valid    (valid),
      .locked   (locked),
      .timeout  (timeout)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Works on the cycle indices of edges seen by sig_in samples delayed by the
   // synchroniser; periods and high times are simple differences of indices.
   int           cyc = 0;
   logic [SYNC:0] hist;         // hist[k] = sig_in sampled k+1 edges ago
   bit           m_meas;
   int           m_last_rise;
   int           m_hlen;
   bit           m_hseen;
   bit           m_have_prev;
   int           m_prev_per;
   int           m_streak;
   int           m_period, m_high;
   bit           m_valid, m_locked, m_timeout;

   always @(posedge clk_in) begin
      bit sv, pv, r, f;
      int per, d;
      cyc++;
      if (!reset) begin
         hist = '0;
         m_meas = 0; m_hseen = 0; m_have_prev = 0; m_streak = 0;
         m_last_rise = 0; m_hlen = 0; m_prev_per = 0;
         m_period = 0; m_high = 0; m_valid = 0; m_locked = 0; m_timeout = 0;
      end else begin
         sv = hist[SYNC-1];
         pv = hist[SYNC];
         r  = sv && !pv;
         f  = !sv && pv;
         m_valid = 0;
         if (f) begin
            m_hlen  = cyc - m_last_rise;
            m_hseen = 1;
         end
         if (r) begin
            if (!m_meas) begin
               m_meas = 1; m_timeout = 0; m_have_prev = 0;
            end else begin
               per      = cyc - m_last_rise;
               m_period = per;
               m_high   = m_hseen ? m_hlen : 0;
               m_valid  = 1;
               if (m_have_prev) begin
                  d = (per > m_prev_per) ? per - m_prev_per : m_prev_per - per;
                  if (d <= TOL) begin
                     m_streak++;
                     if (m_streak >= LOCK_CNT) m_locked = 1;
                  end else begin
                     m_streak = 0;
                     m_locked = 0;
                  end
               end
               m_prev_per  = per;
               m_have_prev = 1;
            end
            m_last_rise = cyc;
            m_hseen     = 0;
         end else if (m_meas && (cyc - m_last_rise == TIMEOUT)) begin
            m_timeout = 1; m_locked = 0; m_streak = 0; m_meas = 0;
         end
         hist = {hist[SYNC-1:0], sig_in};
      end
   end

   // ---------------- compare process + observation ----------------
   int vcount = 0;
   int lock_hist[0:15];
   bit lock_seen = 0;

   always @(posedge clk_in) begin
      #1;
      check("period",    period,    m_period);
      check("high_time", high_time, m_high);
      check("valid",     valid,     m_valid);
      check("locked",    locked,    m_locked);
      check("timeout",   timeout,   m_timeout);
      if (valid === 1'b1) begin
         vcount++;
         if (vcount < 16) lock_hist[vcount] = locked;
      end
      if (locked === 1'b1) lock_seen = 1;
   end

   task automatic hold(input logic v, input int n);
      sig_in = v;
      repeat (n) @(negedge clk_in);
   endtask

   // ---------------- stimulus with literal expectations ----------------
   initial begin
      int vsnap;
      reset  = 1'b0;
      sig_in = 1'b0;
      repeat (3) @(negedge clk_in);
      check("rst_period",  period,    0);
      check("rst_high",    high_time, 0);
      check("rst_valid",   valid,     0);
      check("rst_locked",  locked,    0);
      check("rst_timeout", timeout,   0);
      reset = 1'b1;
      hold(0, 5);

      // Square wave, half period 501
      vcount = 0;
      for (int i = 0; i < 7; i++) begin
         hold(1, 501);
         hold(0, 501);
      end
      check("sq_valids",   vcount, 6);
      check("sq_lock4",    lock_hist[4], 0);
      check("sq_lock5",    lock_hist[5], 1);
      check("sq_period",   period, 1002);
      check("sq_high",     high_time, 501);

      // Alternating 1010 / 1002
      hold(1, 505);
      hold(0, 505);
      hold(1, 10);
      lock_seen = 0;
      hold(1, 491);
      hold(0, 501);
      for (int i = 0; i < 4; i++) begin
         if (i % 2 == 0) begin
            hold(1, 505);
            hold(0, 505);
         end else begin
            hold(1, 501);
            hold(0, 501);
         end
      end
      hold(1, 20);
      check("alt_never_locked", lock_seen, 0);
      check("alt_period",       period, 1002);
      check("alt_high",         high_time, 501);

      // Lock, then lose the input
      hold(1, 481);
      hold(0, 501);
      for (int i = 0; i < 5; i++) begin
         hold(1, 501);
         hold(0, 501);
      end
      hold(1, 501);
      check("to_locked_before", locked, 1);
      hold(0, 3100);
      check("to_timeout",     timeout, 1);
      check("to_locked",      locked, 0);
      check("to_period_kept", period, 1002);
      vsnap = vcount;
      hold(1, 501);
      check("to_cleared",     timeout, 0);
      check("to_no_valid",    vcount, vsnap);
      hold(0, 501);
      hold(1, 501);
      check("to_resume_valid", vcount, vsnap + 1);
      check("to_resume_per",   period, 1002);
      hold(0, 501);

      // One-cycle glitches every 30 cycles, plus a sub-cycle pulse
      for (int i = 0; i < 6; i++) begin
         hold(1, 1);
         hold(0, 29);
      end
      check("gl_period", period, 30);
      check("gl_high",   high_time, 1);
      hold(1, 1);
      hold(0, 10);
      #2 sig_in = 1'b1;
      #2 sig_in = 1'b0;
      @(negedge clk_in);
      hold(0, 18);
      hold(1, 1);
      hold(0, 29);
      check("sub_period", period, 30);
      check("sub_high",   high_time, 1);

      // Reset during the high phase
      hold(1, 50);
      reset = 1'b0;
      @(negedge clk_in);
      check("mr_period",  period, 0);
      check("mr_high",    high_time, 0);
      check("mr_valid",   valid, 0);
      check("mr_locked",  locked, 0);
      check("mr_timeout", timeout, 0);
      reset = 1'b1;
      vsnap = vcount;
      hold(1, 50);
      hold(0, 50);
      check("mr_first_no_valid", vcount, vsnap);
      hold(1, 50);
      hold(0, 50);
      check("mr_period_after", period, 100);

      // Rise coincident with cnt == TIMEOUT
      reset = 1'b0;
      @(negedge clk_in);
      reset = 1'b1;
      hold(0, 5);
      hold(1, 100);
      hold(0, 2900);
      vsnap = vcount;
      hold(1, 100);
      check("co_valid",   vcount, vsnap + 1);
      check("co_period",  period, TIMEOUT);
      check("co_timeout", timeout, 0);
      hold(0, 3100);
      check("co_late_timeout", timeout, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
